game_step_ctrl: RTL and testbench
=================================

Name: game_step_ctrl

Overview:
- Parametrised sequential successor of the 2048 step logic. Holds an N x N board and, per step, spawns one tile into an empty cell, then tries up to four move directions in a caller-given priority order.
- Commits the first movable result, or flags stuck.
- Uses an external combinational merge unit through a request/result port pair.
- Sits between the board source (initial load) and the display/host, which issues start pulses.

Parameters:
BOARD_N, 4, board side length; power of two, 2..8; NC = BOARD_N*BOARD_N cells
CELL_W, 5, bits per cell; value 0 = empty, v>0 = tile 2^v
LFSR_SEED, 16'hACE1, nonzero reset value of internal 16-bit LFSR
PROB4_THRESH, 8'd26, spawn tile 2^2 when lfsr[15:8] < PROB4_THRESH, else 2^1
WIN_EXP, 11, win flag when any cell >= this value

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
load  in  1  load board_in into board register (honoured only in IDLE)
board_in  in  NC*CELL_W  initial board; cell i at [i*CELL_W +: CELL_W], i = row*BOARD_N+col
start  in  1  begin one step (honoured only in IDLE with stuck=0)
mov_seq  in  8  direction priority; entry k at [2k+1:2k]; captured on accepted start
merge_board_out  out  NC*CELL_W  board presented to merge unit (= board register)
merge_dir  out  2  direction presented to merge unit
merge_board_in  in  NC*CELL_W  merge unit result, same cycle
merge_movable  in  1  merge unit: move changes the board
board  out  NC*CELL_W  current board register
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of step
stuck  out  1  sticky: no direction movable
last_dir  out  2  direction committed by last successful step
win  out  1  combinational: any cell >= WIN_EXP

Behaviour:
- Reset (rst=0, async): board=0, state=IDLE, busy=0, done=0, stuck=0, last_dir=0, lfsr=LFSR_SEED, idx=0. Asserting reset mid-step aborts the step immediately; no partial commit.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Advances every clock out of reset.
- IDLE:
  - load=1: board<=board_in; stuck<=0; load has priority over start in the same cycle.
  - start=1 and stuck=0: capture mov_seq; idx<=0.
  - Capture spos = lfsr[log2(NC)-1:0].
  - Capture spawn = (lfsr[15:8] < PROB4_THRESH) ? 2 : 1.
  - Go to TRY if no cell is empty, else to FILL.
  - start while stuck=1 is ignored: no busy, no done.
- FILL: examine one cell per cycle, starting at spos and scanning upward with wrap NC-1 -> 0.
  - First empty cell found: write spawn into it; go to TRY.
  - Entry into FILL guarantees an empty cell exists, so the scan takes at most NC cycles.
- TRY: merge_dir = mov_seq entry idx; merge_board_out = board.
  - merge_movable=1: board<=merge_board_in; last_dir<=merge_dir; go to DONE.
  - Else if idx==3: stuck<=1; board unchanged (spawned tile retained); go to DONE.
  - Else idx<=idx+1; stay in TRY.
- DONE: done=1 for this one cycle; go to IDLE. busy deasserts with the transition to IDLE.
- Latency from accepted start to done:
  - With fill: 1 + (FILL cycles, 1..NC) + (TRY cycles, 1..4) + 1.
  - Board full: 1 + (TRY cycles) + 1.
- merge_board_out/merge_dir are valid in every state; only TRY samples the merge result.
- load/start during busy are ignored.

Optional Feature:
- STEP_CNT_EN defined: adds output step_count [15:0]. Reset 0; increments by 1 on each committed move (not on stuck); saturates at 16'hFFFF; cleared by load.
- Undefined: no step_count port and no counter logic.

Test Plan:
- Reset release, load empty board, start, mov_seq=8'hE4, merge_movable=1 -> one cell = 1 or 2 before commit; done 1 cycle after the TRY cycle; last_dir=0; stuck=0.
- Load board with only cell 5 empty, spos forced via LFSR_SEED so spos=3 -> FILL runs 3 cycles (cells 3,4,5); cell 5 gets spawn; total start-to-done = 6 cycles with first direction movable.
- Full board, merge_movable=0 for all dirs, mov_seq=8'h1B -> merge_dir sequence 3,2,1,0; board unchanged; stuck=1; done pulse; later start ignored; load clears stuck.
- merge_movable=1 only when merge_dir=2, mov_seq=8'hE4 -> two rejected TRY cycles, commit on third; last_dir=2; board equals merge_board_in.
- Async reset asserted mid-FILL -> board=0, busy=0, done=0 immediately, no spawn written; load+start in same IDLE cycle -> load only.
- Board with cell 0 = 11 (WIN_EXP) -> win=1; with STEP_CNT_EN, three committed steps -> step_count=3, stuck step leaves it 3.

Source files
------------

// File: rtl/game_step_ctrl.sv
// game_step_ctrl: 2048 step sequencer, spawn one tile then try moves in order.
// Optional macro STEP_CNT_EN adds a saturating step_count output.

module game_step_ctrl #(
  parameter int          BOARD_N      = 4,
  parameter int          CELL_W       = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [7:0]  PROB4_THRESH = 8'd26,
  parameter int          WIN_EXP      = 11
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load,
  input  logic [BOARD_N*BOARD_N*CELL_W-1:0]   board_in,
  input  logic                                start,
  input  logic [7:0]                          mov_seq,
  output logic [BOARD_N*BOARD_N*CELL_W-1:0]   merge_board_out,
  output logic [1:0]                          merge_dir,
  input  logic [BOARD_N*BOARD_N*CELL_W-1:0]   merge_board_in,
  input  logic                                merge_movable,
  output logic [BOARD_N*BOARD_N*CELL_W-1:0]   board,
  output logic                                busy,
  output logic                                done,
  output logic                                stuck,
  output logic [1:0]                          last_dir,
  output logic                                win
`ifdef STEP_CNT_EN
  ,
  output logic [15:0]                         step_count
`endif
);

  localparam int NC  = BOARD_N * BOARD_N;
  localparam int NCW = NC * CELL_W;
  localparam int PW  = $clog2(NC);
  localparam logic [31:0] WIN_L = WIN_EXP;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_TRY,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NCW-1:0]     board_q, board_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [7:0]         seq_q, seq_d;
  logic [1:0]         idx_q, idx_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [CELL_W-1:0]  spawn_q, spawn_d;
  logic               stuck_q, stuck_d;
  logic [1:0]         ldir_q, ldir_d;
`ifdef STEP_CNT_EN
  logic [15:0]        cnt_q, cnt_d;
`endif

  logic [CELL_W-1:0]  cells [NC];
  logic               any_empty;
  logic [1:0]         dir;

  // Unpack the board and derive the empty / win summaries.
  always_comb begin
    any_empty = 1'b0;
    win       = 1'b0;
    for (int i = 0; i < NC; i++) begin
      cells[i] = board_q[i*CELL_W +: CELL_W];
      if (cells[i] == '0) any_empty = 1'b1;
      if (32'(cells[i]) >= WIN_L) win = 1'b1;
    end
  end

  // Direction under trial selected from the captured priority list.
  always_comb begin
    dir = seq_q[1:0];
    unique case (idx_q)
      2'd0: dir = seq_q[1:0];
      2'd1: dir = seq_q[3:2];
      2'd2: dir = seq_q[5:4];
      2'd3: dir = seq_q[7:6];
    endcase
  end

  // Galois LFSR, taps x^16+x^14+x^13+x^11+1.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Step sequencer: next state and datapath updates.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    spawn_d = spawn_q;
    stuck_d = stuck_q;
    ldir_d  = ldir_q;
    done    = 1'b0;
`ifdef STEP_CNT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          board_d = board_in;
          stuck_d = 1'b0;
`ifdef STEP_CNT_EN
          cnt_d   = '0;
`endif
        end else if (start && !stuck_q) begin
          seq_d   = mov_seq;
          idx_d   = 2'd0;
          pos_d   = lfsr_q[PW-1:0];
          spawn_d = (lfsr_q[15:8] < PROB4_THRESH) ?
                    CELL_W'(2) : CELL_W'(1);
          state_d = any_empty ? S_FILL : S_TRY;
        end
      end
      S_FILL: begin
        if (cells[pos_q] == '0) begin
          for (int i = 0; i < NC; i++) begin
            if (PW'(i) == pos_q) begin
              board_d[i*CELL_W +: CELL_W] = spawn_q;
            end
          end
          state_d = S_TRY;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      S_TRY: begin
        if (merge_movable) begin
          board_d = merge_board_in;
          ldir_d  = dir;
`ifdef STEP_CNT_EN
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
          state_d = S_DONE;
        end else if (idx_q == 2'd3) begin
          stuck_d = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any step in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      board_q <= '0;
      lfsr_q  <= LFSR_SEED;
      seq_q   <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      spawn_q <= '0;
      stuck_q <= 1'b0;
      ldir_q  <= '0;
`ifdef STEP_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      lfsr_q  <= lfsr_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      spawn_q <= spawn_d;
      stuck_q <= stuck_d;
      ldir_q  <= ldir_d;
`ifdef STEP_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign merge_board_out = board_q;
  assign merge_dir       = dir;
  assign board           = board_q;
  assign busy            = (state_q != S_IDLE);
  assign stuck           = stuck_q;
  assign last_dir        = ldir_q;
`ifdef STEP_CNT_EN
  assign step_count      = cnt_q;
`endif

endmodule

// File: tb/tb_game_step_ctrl.sv
// tb_game_step_ctrl: randomized self-checking bench for game_step_ctrl.
// Merge unit is modelled as board ^ salt[dir], movable per mask bit.

module tb_game_step_ctrl;

  localparam int NC = 16;
  localparam int CW = 5;
  localparam int W  = NC * CW;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] board_in = '0;
  logic [7:0]   mov_seq = '0;
  logic [W-1:0] merge_board_out;
  logic [1:0]   merge_dir;
  logic [W-1:0] merge_board_in;
  logic         merge_movable;
  logic [W-1:0] board;
  logic         busy, done, stuck, win;
  logic [1:0]   last_dir;
`ifdef STEP_CNT_EN
  logic [15:0]  step_count;
`endif

  logic [3:0]   mask = 4'hF;
  logic [W-1:0] salt [4];
  logic [15:0]  m_lfsr;
  logic [1:0]   m_last_dir = 2'd0;
  logic [1:0]   seen [$];
  int           nchk = 0;
  int           nerr = 0;

  game_step_ctrl dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .board_in(board_in),
    .start(start),
    .mov_seq(mov_seq),
    .merge_board_out(merge_board_out),
    .merge_dir(merge_dir),
    .merge_board_in(merge_board_in),
    .merge_movable(merge_movable),
    .board(board),
    .busy(busy),
    .done(done),
    .stuck(stuck),
    .last_dir(last_dir),
    .win(win)
`ifdef STEP_CNT_EN
    ,
    .step_count(step_count)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    merge_movable  = mask[merge_dir];
    merge_board_in = merge_board_out ^ salt[merge_dir];
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [W-1:0] rand_board(input bit full);
    logic [W-1:0] r = '0;
    for (int i = 0; i < NC; i++) begin
      if (!full && $urandom_range(0, 2) == 0) r[i*CW +: CW] = '0;
      else r[i*CW +: CW] = CW'($urandom_range(1, 12));
    end
    return r;
  endfunction

  function automatic logic [W-1:0] const_board(input int v, input int hole);
    logic [W-1:0] r = '0;
    for (int i = 0; i < NC; i++)
      r[i*CW +: CW] = (i == hole) ? CW'(0) : CW'(v);
    return r;
  endfunction

  function automatic bit has_win(input logic [W-1:0] b);
    for (int i = 0; i < NC; i++)
      if (b[i*CW +: CW] >= CW'(11)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: one step from the spec's rules, returns outcome and latency.
  function automatic void ref_step(
    input  logic [W-1:0] b,
    input  logic [15:0]  l,
    input  logic [7:0]   seq,
    output logic [W-1:0] nb,
    output bit           st,
    output logic [1:0]   d,
    output int           lat,
    output int           nf
  );
    int sp = int'(l[3:0]);
    int val = (l[15:8] < 8'd26) ? 2 : 1;
    int ntry = 4;
    bit found = 1'b0;
    nb = b;
    nf = 0;
    st = 1'b1;
    d = 2'd0;
    for (int k = 0; k < NC; k++) begin
      int c = (sp + k) % NC;
      if (!found && b[c*CW +: CW] == '0) begin
        nb[c*CW +: CW] = CW'(val);
        nf = k + 1;
        found = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      logic [1:0] dd = 2'((seq >> (2 * k)) & 8'h3);
      if (st && mask[dd]) begin
        nb = nb ^ salt[dd];
        d = dd;
        st = 1'b0;
        ntry = k + 1;
      end
    end
    lat = 1 + nf + ntry + 1;
  endfunction

  // Call just after a negedge; returns at a negedge.
  task automatic do_load(input logic [W-1:0] b);
    load = 1'b1;
    board_in = b;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Call just after a negedge; measures start-to-done latency in cycles.
  task automatic do_step(
    input  logic [7:0]  seq,
    output int          lat,
    output bit          pok,
    output logic [15:0] l0
  );
    int k = 1;
    start = 1'b1;
    mov_seq = seq;
    l0 = m_lfsr;
    @(negedge clk);
    start = 1'b0;
    seen.delete();
    while (done !== 1'b1 && k < 300) begin
      seen.push_back(merge_dir);
      @(negedge clk);
      k++;
    end
    lat = (done === 1'b1) ? k + 1 : 0;
    @(negedge clk);
    pok = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic new_salt();
    for (int i = 0; i < 4; i++)
      salt[i] = W'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nchk++;
    if (board !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL reset_main board=%h busy=%b done=%b exp 0",
               board, busy, done);
    end
    nchk++;
    if (stuck !== 1'b0 || last_dir !== 2'd0 || win !== 1'b0) begin
      nerr++;
      $display("FAIL reset_flags stuck=%b last_dir=%0d win=%b exp 0",
               stuck, last_dir, win);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] nb, diff;
    bit st, pok;
    logic [1:0] d;
    int lat, elat, nf, nz;
    logic [15:0] l0;
    mask = 4'hF;
    new_salt();
    do_load('0);
    do_step(8'hE4, lat, pok, l0);
    ref_step('0, l0, 8'hE4, nb, st, d, elat, nf);
    nchk++;
    if (lat !== elat) begin
      nerr++;
      $display("FAIL basic_lat got %0d exp %0d", lat, elat);
    end
    nchk++;
    if (board !== nb) begin
      nerr++;
      $display("FAIL basic_board got %h exp %h", board, nb);
    end
    nchk++;
    if (last_dir !== 2'd0 || stuck !== 1'b0 || !pok) begin
      nerr++;
      $display("FAIL basic_flags dir=%0d stuck=%b pulse=%b exp 0 0 1",
               last_dir, stuck, pok);
    end
    diff = board ^ salt[0];
    nz = 0;
    for (int i = 0; i < NC; i++)
      if (diff[i*CW +: CW] == CW'(1) || diff[i*CW +: CW] == CW'(2)) nz++;
      else if (diff[i*CW +: CW] != '0) nz += 100;
    nchk++;
    if (nz !== 1) begin
      nerr++;
      $display("FAIL basic_spawn tiles got %0d exp 1", nz);
    end
    m_last_dir = 2'd0;
  endtask

  task automatic test_fill_latency();
    logic [W-1:0] b, nb;
    bit st, pok;
    logic [1:0] d;
    int lat, elat, nf, n;
    logic [15:0] l0;
    mask = 4'hF;
    new_salt();
    b = const_board(3, 5);
    do_load(b);
    n = 0;
    while (m_lfsr[3:0] != 4'd3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    do_step(8'hE4, lat, pok, l0);
    ref_step(b, l0, 8'hE4, nb, st, d, elat, nf);
    nchk++;
    if (lat !== 6) begin
      nerr++;
      $display("FAIL fill_lat got %0d exp 6", lat);
    end
    nchk++;
    if (board !== nb || !pok) begin
      nerr++;
      $display("FAIL fill_board got %h exp %h pulse=%b", board, nb, pok);
    end
    m_last_dir = 2'd0;
  endtask

  task automatic test_stuck();
    logic [W-1:0] b;
    bit pok, bad;
    int lat;
    logic [15:0] l0;
    mask = 4'h0;
    b = rand_board(1'b1);
    do_load(b);
    do_step(8'h1B, lat, pok, l0);
    nchk++;
    if (lat !== 6 || !pok) begin
      nerr++;
      $display("FAIL stuck_lat got %0d pulse=%b exp 6 1", lat, pok);
    end
    nchk++;
    if (board !== b || stuck !== 1'b1 || last_dir !== m_last_dir) begin
      nerr++;
      $display("FAIL stuck_state board=%h stuck=%b dir=%0d exp %h 1 %0d",
               board, stuck, last_dir, b, m_last_dir);
    end
    for (int k = 0; k < 4; k++) begin
      nchk++;
      if (seen.size() <= k || seen[k] !== 2'(3 - k)) begin
        nerr++;
        $display("FAIL stuck_dir%0d got %0d exp %0d", k,
                 (seen.size() > k) ? seen[k] : 2'd0, 3 - k);
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    nchk++;
    if (bad) begin
      nerr++;
      $display("FAIL stuck_ignore busy/done seen got 1 exp 0");
    end
    do_load(b);
    nchk++;
    if (stuck !== 1'b0) begin
      nerr++;
      $display("FAIL stuck_clear got %b exp 0", stuck);
    end
  endtask

  task automatic test_third_dir();
    logic [W-1:0] b, nb;
    bit st, pok;
    logic [1:0] d;
    int lat, elat, nf;
    logic [15:0] l0;
    mask = 4'b0100;
    new_salt();
    b = const_board(4, 9);
    do_load(b);
    do_step(8'hE4, lat, pok, l0);
    ref_step(b, l0, 8'hE4, nb, st, d, elat, nf);
    nchk++;
    if (lat !== elat || board !== nb) begin
      nerr++;
      $display("FAIL third_step lat=%0d board=%h exp %0d %h",
               lat, board, elat, nb);
    end
    nchk++;
    if (last_dir !== 2'd2 || stuck !== 1'b0) begin
      nerr++;
      $display("FAIL third_dir got %0d stuck=%b exp 2 0", last_dir, stuck);
    end
    for (int k = 0; k < 3; k++) begin
      nchk++;
      if (seen.size() <= nf + k || seen[nf + k] !== 2'(k)) begin
        nerr++;
        $display("FAIL third_try%0d got %0d exp %0d", k,
                 (seen.size() > nf + k) ? seen[nf + k] : 2'd3, k);
      end
    end
    m_last_dir = 2'd2;
  endtask

  task automatic test_load_start();
    logic [W-1:0] b;
    b = rand_board(1'b0);
    mask = 4'hF;
    load = 1'b1;
    start = 1'b1;
    board_in = b;
    mov_seq = 8'hE4;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    nchk++;
    if (board !== b || busy !== 1'b0) begin
      nerr++;
      $display("FAIL ldst_load board=%h busy=%b exp %h 0", board, busy, b);
    end
    @(negedge clk);
    nchk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL ldst_idle busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_win();
    logic [W-1:0] b;
    b = '0;
    b[4:0] = 5'd11;
    do_load(b);
    nchk++;
    if (win !== 1'b1) begin
      nerr++;
      $display("FAIL win_at11 got %b exp 1", win);
    end
    do_load(const_board(10, 99));
    nchk++;
    if (win !== 1'b0) begin
      nerr++;
      $display("FAIL win_at10 got %b exp 0", win);
    end
  endtask

  task automatic test_step_count();
`ifdef STEP_CNT_EN
    bit pok;
    int lat;
    logic [15:0] l0;
    mask = 4'hF;
    new_salt();
    do_load('0);
    nchk++;
    if (step_count !== 16'd0) begin
      nerr++;
      $display("FAIL cnt_load got %0d exp 0", step_count);
    end
    repeat (3) do_step(8'h39, lat, pok, l0);
    nchk++;
    if (step_count !== 16'd3) begin
      nerr++;
      $display("FAIL cnt_three got %0d exp 3", step_count);
    end
    mask = 4'h0;
    do_step(8'h39, lat, pok, l0);
    nchk++;
    if (step_count !== 16'd3 || stuck !== 1'b1) begin
      nerr++;
      $display("FAIL cnt_stuck got %0d stuck=%b exp 3 1", step_count, stuck);
    end
    m_last_dir = 2'd1;
    do_load('0);
    nchk++;
    if (step_count !== 16'd0) begin
      nerr++;
      $display("FAIL cnt_clear got %0d exp 0", step_count);
    end
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] b, nb;
    bit st, pok;
    logic [1:0] d;
    int lat, elat, nf;
    logic [15:0] l0;
    logic [7:0] seq;
    for (int it = 0; it < 24; it++) begin
      b = rand_board(it % 4 == 0);
      seq = 8'($urandom());
      mask = 4'($urandom());
      new_salt();
      do_load(b);
      nchk++;
      if (win !== has_win(b)) begin
        nerr++;
        $display("FAIL rnd%0d_win got %b exp %b", it, win, has_win(b));
      end
      do_step(seq, lat, pok, l0);
      ref_step(b, l0, seq, nb, st, d, elat, nf);
      if (!st) m_last_dir = d;
      nchk++;
      if (lat !== elat || !pok) begin
        nerr++;
        $display("FAIL rnd%0d_lat got %0d pulse=%b exp %0d", it, lat, pok,
                 elat);
      end
      nchk++;
      if (board !== nb || stuck !== st || last_dir !== m_last_dir) begin
        nerr++;
        $display("FAIL rnd%0d_state board=%h st=%b dir=%0d exp %h %b %0d",
                 it, board, stuck, last_dir, nb, st, m_last_dir);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] b;
    bit bad;
    int n;
    mask = 4'hF;
    b = const_board(3, 7);
    do_load(b);
    n = 0;
    while (m_lfsr[3:0] != 4'd8 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    mov_seq = 8'hE4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    nchk++;
    if (board !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL rstmid_now board=%h busy=%b done=%b exp 0",
               board, busy, done);
    end
    m_last_dir = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (board !== '0 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    nchk++;
    if (bad) begin
      nerr++;
      $display("FAIL rstmid_after activity got 1 exp 0");
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) salt[i] = '0;
    test_reset();
    test_basic();
    test_fill_latency();
    test_stuck();
    test_third_dir();
    test_load_start();
    test_win();
    test_step_count();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
